// File: rtl/aes_dec_iter_if.sv
// Block handshake bundle for aes_dec_iter: ciphertext/key in, plaintext out.
// Byte 0 of every 128-bit field sits in bits [127:120].
interface aes_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] cipher_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    modport master (
        output in_valid, ciphertext, cipher_key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, cipher_key, out_ready,
        output in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys regenerated
// backwards from rk10, with an optional single-entry cache of the last rk10.
module aes_dec_iter #(
    parameter bit CACHE_KEY = 1'b1
) (
    input logic           clk,
    input logic           rst,
    aes_dec_iter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ARK, S_ROUND, S_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, s;
        r = 8'h01;
        s = a;
        for (int unsigned i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_sched(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_sched(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] v0, v1, v2, v3;
        v3 = k[31:0] ^ k[63:32];
        v2 = k[63:32] ^ k[95:64];
        v1 = k[95:64] ^ k[127:96];
        v0 = k[127:96] ^ sub_rot(v3) ^ {rc, 24'h0};
        return {v0, v1, v2, v3};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last round.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [127:0] t, o;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                a[4*c+r] = inv_sbox(s[8*(15 - (4*((c + 4 - r) % 4) + r)) +: 8]);
        for (int unsigned i = 0; i < 16; i++)
            t[8*(15-i) +: 8] = a[i] ^ rk[8*(15-i) +: 8];
        o = t;
        if (!last) begin
            for (int unsigned c = 0; c < 4; c++) begin
                a0 = t[8*(15-4*c) +: 8];
                a1 = t[8*(14-4*c) +: 8];
                a2 = t[8*(13-4*c) +: 8];
                a3 = t[8*(12-4*c) +: 8];
                o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return o;
    endfunction

    state_t       r_state;
    logic [127:0] r_blk, r_key, r_pt, r_cache_key, r_cache_rk;
    logic [7:0]   r_rcon;
    logic [3:0]   r_cnt;
    logic         r_out_valid, r_cache_vld;
    logic [127:0] w_key_next, w_rk_prev, w_round;
    logic         w_hit;

    assign w_key_next = fwd_sched(r_key, r_rcon);
    assign w_rk_prev  = inv_sched(r_key, r_rcon);
    assign w_round    = inv_round(r_blk, w_rk_prev, r_cnt == 4'd0);
    assign w_hit      = CACHE_KEY && r_cache_vld && (bus.cipher_key == r_cache_key);

    assign bus.in_ready  = (r_state == S_IDLE) & ~rst;
    assign bus.out_valid = r_out_valid;
    assign bus.plaintext = r_pt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_blk       <= '0;
            r_key       <= '0;
            r_pt        <= '0;
            r_cache_key <= '0;
            r_cache_rk  <= '0;
            r_rcon      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_cache_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_blk  <= bus.ciphertext;
                    r_cnt  <= '0;
                    r_rcon <= 8'h01;
                    if (w_hit) begin
                        r_key   <= r_cache_rk;
                        r_state <= S_ARK;
                    end else begin
                        // Tag written now, entry only becomes valid once rk10 is stored.
                        r_key       <= bus.cipher_key;
                        r_cache_key <= bus.cipher_key;
                        r_cache_vld <= 1'b0;
                        r_state     <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    r_key  <= w_key_next;
                    r_rcon <= xtime(r_rcon);
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_cache_rk  <= w_key_next;
                        r_cache_vld <= 1'b1;
                        r_state     <= S_ARK;
                    end
                end
                S_ARK: begin
                    r_blk   <= r_blk ^ r_key;
                    r_rcon  <= 8'h36;
                    r_cnt   <= 4'd9;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_blk  <= w_round;
                    r_key  <= w_rk_prev;
                    r_rcon <= (r_rcon == 8'h1b) ? 8'h80 : (r_rcon >> 1);
                    if (r_cnt == 4'd0) begin
                        r_pt        <= w_round;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_dec_iter.sv
// Bench for aes_dec_iter: FIPS-197 vectors, cache/latency, backpressure, reset abort,
// and random round trips against a forward AES-128 reference built from GF(2^8) rules.
module tb_aes_dec_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [7:0] sb [256];

    aes_dec_iter_if bus ();

    aes_dec_iter #(.CACHE_KEY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int unsigned  lat;
    } vec_t;

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rl(input int q, input int n);
        return ((q << n) | (q >> (8 - n))) & 255;
    endfunction

    function automatic int xt(input int a);
        return ((a << 1) ^ (((a & 128) != 0) ? 'h11b : 0)) & 255;
    endfunction

    // S-box from walking the generator 3 and its inverse 3^-1 through the field.
    task automatic build_sbox();
        int p, q, x;
        p = 1;
        q = 1;
        do begin
            p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 'h1b : 0)) & 255;
            q = (q ^ (q << 1)) & 255;
            q = (q ^ (q << 2)) & 255;
            q = (q ^ (q << 4)) & 255;
            if ((q & 128) != 0) q = q ^ 'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = 8'(x ^ 'h63);
        end while (p != 1);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [127:0] o;
        int rc, a0, a1, a2, a3;
        int s [16];
        int t [16];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 1;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {8'(rc), 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = int'(p[127-8*i -: 8]) ^ int'(w[i/4][31-8*(i%4) -: 8]);
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = int'(sb[s[i]]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ int'(w[4*r + i/4][31-8*(i%4) -: 8]);
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = 8'(s[i]);
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block and wait for acceptance; returns the accept cycle index.
    task automatic offer(input string nm, input logic [127:0] key, input logic [127:0] ct,
                         output int unsigned acc, output bit ok);
        int unsigned guard;
        bus.cipher_key = key;
        bus.ciphertext = ct;
        bus.in_valid   = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok  = bus.in_ready;
        acc = cyc;
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL %s_accept: got in_ready=0 expected 1 within 100 cycles", nm);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.ciphertext = rnd128();
        bus.cipher_key = rnd128();
    endtask

    task automatic run_block(input string nm, input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] exp_pt, input int unsigned exp_lat,
                             input bit rand_ready);
        int unsigned acc, guard;
        bit ok;
        offer(nm, key, ct, acc, ok);
        if (!ok) return;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.out_valid) begin
            n_chk++; n_err++;
            $display("FAIL %s_done: got out_valid=0 expected 1 within 100 cycles", nm);
            return;
        end
        chk_n({nm, "_lat"}, cyc - acc, exp_lat);
        bus.out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        guard = 0;
        while (!bus.out_ready && guard < 6) begin
            @(negedge clk);
            guard++;
            bus.out_ready = 1'($urandom % 2);
        end
        bus.out_ready = 1'b1;
        chk({nm, "_pt"}, bus.plaintext, exp_pt);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    // Abort a block with reset a fixed number of cycles after acceptance.
    task automatic abort_block(input string nm, input logic [127:0] key, input logic [127:0] ct,
                               input int unsigned at);
        int unsigned acc;
        bit ok;
        logic [127:0] prev_pt;
        prev_pt = bus.plaintext;
        offer(nm, key, ct, acc, ok);
        if (!ok) return;
        while (cyc - acc < at) @(negedge clk);
        chk({nm, "_busy"}, {bus.in_ready, bus.out_valid, bus.plaintext}, {2'b00, prev_pt});
        rst = 1'b1;
        #1;
        chk({nm, "_rst"}, {bus.in_ready, bus.out_valid, bus.plaintext}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({nm, "_rel"}, {bus.in_ready, bus.out_valid}, 2'b10);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [4];
        logic [127:0] k, p;
        int unsigned acc, guard, stable, busy_rdy;
        bit ok;

        vecs[0] = '{K_C1, C_C1, P_C1, 22};
        vecs[1] = '{K_B,  C_B,  P_B,  22};
        vecs[2] = '{K_B,  C_B,  P_B,  12};
        vecs[3] = '{K_C1, C_C1, P_C1, 22};

        build_sbox();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ciphertext = '0;
        bus.cipher_key = '0;

        repeat (3) @(negedge clk);
        chk("reset_hold", {bus.in_ready, bus.out_valid, bus.plaintext}, '0);
        rst = 1'b0;
        #1;
        chk("reset_release", {bus.in_ready, bus.out_valid, bus.plaintext}, {2'b10, 128'h0});
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, 1'b0);

        // Backpressure on a cache hit, with stray in_valid pulses while busy.
        offer("bp", K_C1, C_C1, acc, ok);
        busy_rdy = 0;
        guard = 0;
        while (ok && !bus.out_valid && guard < 100) begin
            if (bus.in_ready) busy_rdy++;
            bus.in_valid   = 1'($urandom % 2);
            bus.ciphertext = rnd128();
            bus.cipher_key = rnd128();
            @(negedge clk);
            guard++;
        end
        chk_n("bp_lat", cyc - acc, 12);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid && bus.plaintext == P_C1 && !bus.in_ready) stable++;
            if (bus.in_ready) busy_rdy++;
            bus.in_valid   = 1'($urandom % 2);
            bus.ciphertext = rnd128();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk_n("bp_stable", stable, 50);
        chk_n("bp_busy_ready", busy_rdy, 0);
        bus.out_ready = 1'b1;
        chk("bp_pt", bus.plaintext, P_C1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle", {bus.in_ready, bus.out_valid, bus.plaintext}, {2'b10, P_C1});

        abort_block("abortB", K_B, C_B, 15);
        run_block("after_abortB", K_C1, C_C1, P_C1, 22, 1'b0);
        abort_block("abortC1hit", K_C1, C_C1, 8);
        run_block("after_abortC1", K_C1, C_C1, P_C1, 22, 1'b0);

        k = rnd128();
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) k = rnd128();
            p = rnd128();
            repeat ($urandom % 3) @(negedge clk);
            run_block($sformatf("rand%0d", i), k, aes_enc(p, k), p, (i % 2 == 0) ? 22 : 12, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
